inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch_skid_buffer.sv | 27 ++
 rtl/inst_fetch.sv | 165 ++++++++++++++++
 tb/tb_inst_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word/PC sizes, IF/ID field
// offsets, the NOP encoding and the fetch FSM state encodings.
package inst_fetch_pkg;

  localparam int WORD_SIZE = 32;
  localparam int PC_SIZE   = 64;

  // IF/ID register layout: {pc, inst}
  localparam int IFID_PC_MSB   = 95;
  localparam int IFID_PC_LSB   = 32;
  localparam int IFID_INST_MSB = 31;
  localparam int IFID_INST_LSB = 0;
  localparam int IFID_RS1_MSB  = 19;
  localparam int IFID_RS1_LSB  = 15;
  localparam int IFID_RS2_MSB  = 24;
  localparam int IFID_RS2_LSB  = 20;
  localparam int IFID_RD_MSB   = 11;
  localparam int IFID_RD_LSB   = 7;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_skid_buffer.sv
// One-entry skid buffer holding a {pc, inst} pair captured while IF/ID is stalled.
// rst is synchronous and active-low; clear takes priority over load.
module if_skid_buffer #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// RISC-V instruction-fetch stage: owns the PC, fetches over req/ack and fills IF/ID.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
//
// Memory handshake: o_imem_req is held high with a stable o_imem_addr until the
// cycle i_imem_ack is seen; i_imem_rdata is consumed only in that cycle.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    PC_WIDTH   = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic                           i_redirect,
  input  logic [PC_WIDTH-1:0]            i_redirect_pc,
  output logic                           o_imem_req,
  output logic [PC_WIDTH-1:0]            o_imem_addr,
  input  logic                           i_imem_ack,
  input  logic [INST_WIDTH-1:0]          i_imem_rdata,
  output logic [PC_WIDTH+INST_WIDTH-1:0] o_if_id_reg,
  output logic                           o_if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                    o_fetch_cnt,
  output logic [31:0]                    o_discard_cnt
`endif
);

  localparam int IFID_W = PC_WIDTH + INST_WIDTH;
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

  fetch_state_t        state, state_next;
  logic [PC_WIDTH-1:0] pc, target;

  logic              skid_valid;
  logic [IFID_W-1:0] skid_data;

  logic pc_from_redirect, pc_from_target, pc_inc;
  logic ifid_from_mem, ifid_from_skid, ifid_bubble;
  logic skid_load, skid_clear, discard_evt, fetch_evt;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_BOOT;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: begin
        if (i_redirect)                   state_next = i_imem_ack ? ST_FETCH : ST_DRAIN;
        else if (i_imem_ack && i_stall)   state_next = ST_HOLD;
      end
      ST_HOLD:  if (i_redirect || !i_stall) state_next = ST_FETCH;
      ST_DRAIN: if (i_imem_ack) state_next = ST_FETCH;
      default:  state_next = ST_BOOT;
    endcase
  end

  // Output / control decode
  always_comb begin
    o_imem_req       = 1'b0;
    pc_from_redirect = 1'b0;
    pc_from_target   = 1'b0;
    pc_inc           = 1'b0;
    ifid_from_mem    = 1'b0;
    ifid_from_skid   = 1'b0;
    ifid_bubble      = 1'b0;
    skid_load        = 1'b0;
    discard_evt      = 1'b0;
    case (state)
      ST_BOOT: pc_from_redirect = i_redirect;
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_redirect) begin
          pc_from_redirect = i_imem_ack;
        end else if (i_imem_ack) begin
          ifid_from_mem = !i_stall;
          pc_inc        = !i_stall;
          skid_load     = i_stall;
        end else begin
          ifid_bubble = !i_stall;
        end
      end
      ST_HOLD: begin
        pc_from_redirect = i_redirect;
        ifid_from_skid   = !i_redirect && !i_stall;
        pc_inc           = !i_redirect && !i_stall;
      end
      ST_DRAIN: begin
        o_imem_req       = 1'b1;
        // The acked word belongs to the abandoned path and is dropped.
        discard_evt      = i_imem_ack;
        pc_from_redirect = i_redirect && i_imem_ack;
        pc_from_target   = !i_redirect && i_imem_ack;
      end
      default: ;
    endcase
    skid_clear = (i_redirect && skid_valid) || ifid_from_skid;
    if (i_redirect && skid_valid) discard_evt = 1'b1;
    fetch_evt = ifid_from_mem || ifid_from_skid;
  end

  assign o_imem_addr = pc;

  if_skid_buffer #(.WIDTH(IFID_W)) u_skid (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   ({pc, i_imem_rdata}),
    .valid (skid_valid),
    .dout  (skid_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pc            <= RESET_PC;
      target        <= RESET_PC;
      o_if_id_reg   <= {RESET_PC, NOP};
      o_if_id_valid <= 1'b0;
    end else begin
      if (i_redirect) target <= i_redirect_pc;

      if (pc_from_redirect)    pc <= i_redirect_pc;
      else if (pc_from_target) pc <= target;
      else if (pc_inc)         pc <= pc + PC_WIDTH'(PC_STEP);

      if (i_redirect) begin
        o_if_id_reg   <= {i_redirect_pc, NOP};
        o_if_id_valid <= 1'b0;
      end else if (ifid_from_mem) begin
        o_if_id_reg   <= {pc, i_imem_rdata};
        o_if_id_valid <= 1'b1;
      end else if (ifid_from_skid) begin
        o_if_id_reg   <= skid_data;
        o_if_id_valid <= 1'b1;
      end else if (ifid_bubble) begin
        o_if_id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_fetch_cnt   <= '0;
      o_discard_cnt <= '0;
    end else begin
      if (fetch_evt)   o_fetch_cnt   <= o_fetch_cnt + 32'd1;
      if (discard_evt) o_discard_cnt <= o_discard_cnt + 32'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ discard_evt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed test-plan scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst, i_stall, i_redirect, i_imem_ack;
  logic [63:0] i_redirect_pc;
  logic [31:0] i_imem_rdata;
  logic        o_imem_req, o_if_id_valid;
  logic [63:0] o_imem_addr;
  logic [95:0] o_if_id_reg;
`ifdef IF_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_discard_cnt;
`endif

  inst_fetch dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_id_reg   (o_if_id_reg),
    .o_if_id_valid (o_if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .o_fetch_cnt   (o_fetch_cnt),
    .o_discard_cnt (o_discard_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: transaction-level view of the fetch stage
  logic [63:0] m_pc, m_target;
  bit          m_boot, m_drain, m_valid;
  logic [95:0] m_ifid;
  logic [95:0] exp_q[$];  // captured-but-not-delivered instructions
  int unsigned m_fetch, m_disc;

  function automatic bit m_req();
    return !m_boot && (m_drain || exp_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_target = 64'h0;
    m_boot = 1; m_drain = 0; m_valid = 0;
    m_ifid = {64'h0, NOP};
    exp_q.delete();
    m_fetch = 0; m_disc = 0;
  endtask

  task automatic model_update();
    if (!i_rst) begin
      model_reset();
    end else if (i_redirect) begin
      m_valid = 0;
      m_ifid  = {i_redirect_pc, NOP};
      if (exp_q.size() != 0) begin
        exp_q.delete();
        m_disc++;
        m_pc = i_redirect_pc;
      end else if (m_boot) begin
        m_boot = 0;
        m_pc = i_redirect_pc;
      end else if (m_drain) begin
        if (i_imem_ack) begin
          m_disc++;
          m_drain = 0;
          m_pc = i_redirect_pc;
        end else begin
          m_target = i_redirect_pc;
        end
      end else if (i_imem_ack) begin
        m_pc = i_redirect_pc;
      end else begin
        m_drain = 1;
        m_target = i_redirect_pc;
      end
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_drain) begin
      if (i_imem_ack) begin
        m_disc++;
        m_drain = 0;
        m_pc = m_target;
      end
    end else if (exp_q.size() != 0) begin
      if (!i_stall) begin
        m_ifid = exp_q.pop_front();
        m_valid = 1;
        m_pc = m_pc + 64'd4;
        m_fetch++;
      end
    end else if (i_imem_ack) begin
      if (i_stall) begin
        exp_q.push_back({m_pc, i_imem_rdata});
      end else begin
        m_ifid = {m_pc, i_imem_rdata};
        m_valid = 1;
        m_pc = m_pc + 64'd4;
        m_fetch++;
      end
    end else if (!i_stall) begin
      m_valid = 0;
    end
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("req", 128'(o_imem_req), 128'(m_req()));
    check("addr", 128'(o_imem_addr), 128'(m_pc));
    check("valid", 128'(o_if_id_valid), 128'(m_valid));
    if (m_valid) check("ifid", 128'(o_if_id_reg), 128'(m_ifid));
    else         check("ifid_inst", 128'(o_if_id_reg[31:0]), 128'(m_ifid[31:0]));
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", 128'(o_fetch_cnt), 128'(m_fetch));
    check("discard_cnt", 128'(o_discard_cnt), 128'(m_disc));
`endif
  endtask

  // Driver: called at negedge; checks, drives, advances one clock
  task automatic step(input bit rst_v, input bit stall_v, input bit redir_v,
                      input logic [63:0] rpc, input bit ack_v, input logic [31:0] rd);
    check_outputs();
    i_rst = rst_v; i_stall = stall_v; i_redirect = redir_v;
    i_redirect_pc = rpc; i_imem_ack = ack_v; i_imem_rdata = rd;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic go(input bit stall_v, input bit redir_v, input logic [63:0] rpc, input bit ack_v);
    step(1'b1, stall_v, redir_v, rpc, ack_v, $urandom);
  endtask

  logic [31:0] saved;
  logic [63:0] rpc_r;
  int          sel;

  initial begin
    i_rst = 0; i_stall = 0; i_redirect = 0; i_redirect_pc = '0;
    i_imem_ack = 0; i_imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    check("rst_ifid", 128'(o_if_id_reg), 128'({64'h0, NOP}));
    check("rst_valid", 128'(o_if_id_valid), 128'(0));
    check("rst_req", 128'(o_imem_req), 128'(0));
    check("rst_addr", 128'(o_imem_addr), 128'(0));
    step(1'b0, 0, 0, 64'h0, 0, 32'h0);

    // Release; an ack during BOOT must be ignored
    go(0, 0, 64'h0, 1);
    check("boot_req", 128'(o_imem_req), 128'(1));
    check("boot_addr", 128'(o_imem_addr), 128'(0));
    for (int i = 0; i < 4; i++) go(0, 0, 64'h0, 1);

    // Slow memory at 0x10
    for (int i = 0; i < 3; i++) begin
      check("slow_addr", 128'(o_imem_addr), 128'(64'h10));
      go(0, 0, 64'h0, 0);
    end
    step(1'b1, 0, 0, 64'h0, 1, 32'hCAFE_0010);
    check("slow_ifid", 128'(o_if_id_reg), 128'({64'h10, 32'hCAFE_0010}));

    // Stall on the ack of 0x20, held 4 cycles
    for (int i = 0; i < 3; i++) go(0, 0, 64'h0, 1);
    saved = $urandom;
    step(1'b1, 1, 0, 64'h0, 1, saved);
    for (int i = 0; i < 3; i++) begin
      check("hold_req", 128'(o_imem_req), 128'(0));
      go(1, 0, 64'h0, 0);
    end
    go(0, 0, 64'h0, 0);
    check("skid_ifid", 128'(o_if_id_reg), 128'({64'h20, saved}));
    check("skid_next_addr", 128'(o_imem_addr), 128'(64'h24));

    // Redirect while 0x40 is outstanding; late response must be dropped
    for (int i = 0; i < 7; i++) go(0, 0, 64'h0, 1);
    check("drain_addr", 128'(o_imem_addr), 128'(64'h40));
    go(0, 1, 64'h100, 0);
    go(0, 0, 64'h0, 0);
    check("drain_hold_addr", 128'(o_imem_addr), 128'(64'h40));
    step(1'b1, 0, 0, 64'h0, 1, 32'hDEAD_BEEF);
    check("drain_no_beef", 128'(o_if_id_reg[31:0] == 32'hDEAD_BEEF), 128'(0));
    check("drain_next_addr", 128'(o_imem_addr), 128'(64'h100));

    // Stall + redirect while holding a skid entry
    go(1, 0, 64'h0, 1);
    go(1, 1, 64'h200, 0);
    check("hold_redir_valid", 128'(o_if_id_valid), 128'(0));
    check("hold_redir_addr", 128'(o_imem_addr), 128'(64'h200));
`ifdef IF_PERF_CNT_EN
    check("hold_redir_disc", 128'(o_discard_cnt), 128'(2));
`endif

    // PC wrap
    go(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    check("wrap_pre", 128'(o_imem_addr), 128'(64'hFFFF_FFFF_FFFF_FFFC));
    go(0, 0, 64'h0, 1);
    check("wrap_addr", 128'(o_imem_addr), 128'(64'h0));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rpc_r = 64'($urandom_range(0, 255)) << 2;
        1:       rpc_r = {$urandom, $urandom};
        2:       rpc_r = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: rpc_r = 64'($urandom_range(0, 4095));
      endcase
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 8,
           rpc_r,
           (m_req() || m_boot) && ($urandom_range(0, 99) < 60),
           $urandom);
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
